// File: rtl/clk_div_gen_pkg.sv
// Shared select encodings, run-state type and elaboration helpers for the clk_div_gen slice.
// No logic; latency and backpressure do not apply.
package clk_gen_pkg;

  localparam logic [1:0] SEL_CLK1 = 2'b00;
  localparam logic [1:0] SEL_CLK2 = 2'b01;
  localparam logic [1:0] SEL_CLK3 = 2'b10;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Ratios must nest so every slower clock edge lands on a faster clock edge.
  function automatic bit div_legal(input int d1, input int d2, input int d3);
    return is_pow2(d1) && is_pow2(d2) && is_pow2(d3) &&
           (d1 >= 2) && (d2 >= d1) && (d3 >= d2);
  endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// Run/select handshake and divided-clock bundle; sel_ack exists only with CLK_DIV_GEN_SEL_ACK_EN.
// Pure wiring: no latency, no backpressure.
interface clk_div_gen_if;
  logic       en;
  logic       sel_load;
  logic [1:0] sel_req;
  logic       clk1;
  logic       clk2;
  logic       clk3;
  logic [1:0] select;
  logic       sel_busy;
  logic       running;
`ifdef CLK_DIV_GEN_SEL_ACK_EN
  logic       sel_ack;
`endif

  modport master (
    output en, sel_load, sel_req,
    input  clk1, clk2, clk3, select, sel_busy, running
`ifdef CLK_DIV_GEN_SEL_ACK_EN
    , input sel_ack
`endif
  );

  modport slave (
    input  en, sel_load, sel_req,
    output clk1, clk2, clk3, select, sel_busy, running
`ifdef CLK_DIV_GEN_SEL_ACK_EN
    , output sel_ack
`endif
  );
endinterface

// File: rtl/clk_div_gen_sel_ctrl.sv
// Holds one pending select request and applies it at the superperiod wrap (or next edge when stopped).
// Latency: capture 1 edge, apply at next wrap; sel_load while busy is dropped. o_sel_ack with CLK_DIV_GEN_SEL_ACK_EN.
module clk_sel_ctrl
  import clk_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sel_load,
  input  logic [1:0] i_sel_req,
  input  logic       i_wrap,
  input  logic       i_running,
`ifdef CLK_DIV_GEN_SEL_ACK_EN
  output logic       o_sel_ack,
`endif
  output logic [1:0] o_select,
  output logic       o_busy
);

  logic [1:0] r_pend;
  logic [1:0] r_select;
  logic       r_busy;
  logic       w_capture;
  logic       w_apply;

  // Apply only needs r_busy, so it can never fire on the capture edge itself.
  assign w_capture = i_sel_load & ~r_busy;
  assign w_apply   = r_busy & (i_wrap | ~i_running);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= SEL_CLK1;
      r_select <= SEL_CLK1;
      r_busy   <= 1'b0;
    end else if (w_capture) begin
      r_pend   <= i_sel_req;
      r_busy   <= 1'b1;
    end else if (w_apply) begin
      r_select <= r_pend;
      r_busy   <= 1'b0;
    end
  end

`ifdef CLK_DIV_GEN_SEL_ACK_EN
  logic r_sel_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sel_ack <= 1'b0;
    else        r_sel_ack <= w_apply;
  end

  assign o_sel_ack = r_sel_ack;
`endif

  assign o_select = r_select;
  assign o_busy   = r_busy;

endmodule

// File: rtl/clk_div_gen.sv
// Master counter plus registered clk/DIV1..DIV3 outputs and glitch-free select source (CLK_DIV_GEN_SEL_ACK_EN adds sel_ack).
// Latency: outputs change on the same edge as the counter; en fall drains to the superperiod wrap, no backpressure.
module clk_div_gen
  import clk_gen_pkg::*;
#(
  parameter int DIV1 = 2,
  parameter int DIV2 = 4,
  parameter int DIV3 = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  clk_div_gen_if.slave bus
);

  localparam int CW = clog2(DIV3);
  localparam int B1 = clog2(DIV1) - 1;
  localparam int B2 = clog2(DIV2) - 1;
  localparam int B3 = clog2(DIV3) - 1;

  if (!div_legal(DIV1, DIV2, DIV3)) begin : g_bad_div
    $error("clk_div_gen: DIV1/DIV2/DIV3 must be nested powers of two, DIV1 >= 2");
  end

  run_state_t  r_state;
  run_state_t  w_state_nxt;
  logic        w_running;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;
  logic        w_wrap;
  logic        r_clk1;
  logic        r_clk2;
  logic        r_clk3;

  assign w_wrap = w_running && (r_cnt == CW'(DIV3 - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_STOP;
    else        r_state <= w_state_nxt;
  end

  // Stopping is only allowed at the wrap so no output pulse is cut short.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STOP: if (bus.en)             w_state_nxt = ST_RUN;
      ST_RUN:  if (w_wrap && !bus.en)  w_state_nxt = ST_STOP;
      default:                         w_state_nxt = ST_STOP;
    endcase
  end

  always_comb begin
    w_running = (r_state == ST_RUN);
  end

  always_comb begin
    w_next_cnt = '0;
    if (w_running && !w_wrap) w_next_cnt = r_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_clk1 <= 1'b0;
      r_clk2 <= 1'b0;
      r_clk3 <= 1'b0;
    end else begin
      r_cnt  <= w_next_cnt;
      r_clk1 <= w_next_cnt[B1];
      r_clk2 <= w_next_cnt[B2];
      r_clk3 <= w_next_cnt[B3];
    end
  end

  clk_sel_ctrl u_sel_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sel_load (bus.sel_load),
    .i_sel_req  (bus.sel_req),
    .i_wrap     (w_wrap),
    .i_running  (w_running),
`ifdef CLK_DIV_GEN_SEL_ACK_EN
    .o_sel_ack  (bus.sel_ack),
`endif
    .o_select   (bus.select),
    .o_busy     (bus.sel_busy)
  );

  assign bus.clk1    = r_clk1;
  assign bus.clk2    = r_clk2;
  assign bus.clk3    = r_clk3;
  assign bus.running = w_running;

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen at DIV 2/4/8: cycle model, select scoreboard and directed handshake scenarios.
module tb_clk_div_gen;
  import clk_gen_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  clk_div_gen_if bus ();

  clk_div_gen #(.DIV1(2), .DIV2(4), .DIV3(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: 3-bit superperiod counter that stops only at its wrap.
  logic [2:0] m_cnt;
  logic       m_run, m_busy, m_ack, m_push_vld;
  logic [1:0] m_pend, m_sel, m_push_dat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 3'd0; m_run <= 1'b0; m_busy <= 1'b0; m_ack <= 1'b0;
      m_pend <= 2'b00; m_sel <= 2'b00; m_push_vld <= 1'b0; m_push_dat <= 2'b00;
    end else begin
      if (m_run) m_cnt <= m_cnt + 3'd1;
      m_run <= bus.en || (m_run && m_cnt != 3'd7);
      m_ack <= 1'b0;
      m_push_vld <= 1'b0;
      if (m_busy && (!m_run || m_cnt == 3'd7)) begin
        m_sel <= m_pend; m_busy <= 1'b0; m_ack <= 1'b1;
      end
      if (bus.sel_load && !m_busy) begin
        m_pend <= bus.sel_req; m_busy <= 1'b1;
        m_push_vld <= 1'b1; m_push_dat <= bus.sel_req;
      end
    end
  end

  logic [1:0] sb_q[$];
  logic       prev_busy;
  logic [2:0] cur_clks;
  int         hi_len[3];

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      prev_busy = 1'b0;
      for (int k = 0; k < 3; k++) hi_len[k] = 0;
    end else begin
      if (m_push_vld) sb_q.push_back(m_push_dat);
      check_val("clk1", bus.clk1, m_cnt[0]);
      check_val("clk2", bus.clk2, m_cnt[1]);
      check_val("clk3", bus.clk3, m_cnt[2]);
      check_val("running", bus.running, m_run);
      check_val("sel_busy", bus.sel_busy, m_busy);
      check_val("select", bus.select, m_sel);
`ifdef CLK_DIV_GEN_SEL_ACK_EN
      check_val("sel_ack", bus.sel_ack, m_ack);
`endif
      if (prev_busy && !bus.sel_busy) begin
        check_val("sb_depth", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) check_val("sb_select", bus.select, sb_q.pop_front());
      end
      prev_busy = bus.sel_busy;
      // Every completed high pulse must be exactly DIVK/2 cycles.
      cur_clks = {bus.clk3, bus.clk2, bus.clk1};
      for (int k = 0; k < 3; k++) begin
        if (cur_clks[k]) hi_len[k]++;
        else begin
          if (hi_len[k] != 0) check_val($sformatf("hi_len_clk%0d", k + 1), hi_len[k], 1 << k);
          hi_len[k] = 0;
        end
      end
    end
  end

  function automatic logic clk_k(input int k);
    case (k)
      0:       return bus.clk1;
      1:       return bus.clk2;
      default: return bus.clk3;
    endcase
  endfunction

  task automatic measure_period(input int k, input int exp);
    int   t0, diff;
    logic last;
    t0 = -1; diff = -1; last = clk_k(k);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!last && clk_k(k)) begin
        if (t0 < 0) t0 = cyc;
        else begin diff = cyc - t0; break; end
      end
      last = clk_k(k);
    end
    check_val($sformatf("period_clk%0d", k + 1), diff, exp);
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (m_cnt == 3'(v)) break;
    end
  endtask

  task automatic wait_busy_fall(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (!bus.sel_busy) begin n = i; break; end
    end
  endtask

  task automatic pulse_load(input logic [1:0] req);
    bus.sel_req = req; bus.sel_load = 1'b1;
    @(posedge clk); #1;
    bus.sel_load = 1'b0;
  endtask

  int n;

  initial begin
    bus.en = 1'b0; bus.sel_load = 1'b0; bus.sel_req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outs", {bus.clk3, bus.clk2, bus.clk1, bus.running, bus.sel_busy}, 5'b0);
    check_val("rst_select", bus.select, SEL_CLK1);

    // Start-up and free-running periods
    rst_n = 1'b1;
    @(posedge clk); #1; bus.en = 1'b1;
    @(posedge clk); #1;
    check_val("run_start", bus.running, 1'b1);
    measure_period(0, 2);
    measure_period(1, 4);
    measure_period(2, 8);

    // Request captured at cnt=3 applies on the 7->0 edge, four edges later
    wait_cnt(3);
    pulse_load(SEL_CLK3);
    check_val("t2_busy", bus.sel_busy, 1'b1);
    wait_busy_fall(n);
    check_val("t2_apply_edges", n, 4);
    check_val("t2_select", bus.select, SEL_CLK3);

    // Second load while busy is dropped
    pulse_load(SEL_CLK2);
    @(posedge clk); #1;
    pulse_load(SEL_CLK3);
    wait_busy_fall(n);
    check_val("t3_select", bus.select, SEL_CLK2);

    // en falls at cnt=2: six more edges to the stop at wrap
    wait_cnt(2);
    bus.en = 1'b0;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (!bus.running) begin n = i; break; end
    end
    check_val("t4_stop_edges", n, 6);
    repeat (4) @(posedge clk);
    #1;
    check_val("t4_idle", {bus.clk3, bus.clk2, bus.clk1, bus.running}, 4'b0);

    // Stopped: apply one edge after capture, including a no-change request
    pulse_load(SEL_CLK2);
    check_val("t5a_busy", bus.sel_busy, 1'b1);
    @(posedge clk); #1;
    check_val("t5a_busy_drop", bus.sel_busy, 1'b0);
    check_val("t5a_select", bus.select, SEL_CLK2);
    pulse_load(SEL_CLK3);
    @(posedge clk); #1;
    check_val("t5b_busy_drop", bus.sel_busy, 1'b0);
    check_val("t5b_select", bus.select, SEL_CLK3);

    // Reset while a request is pending at cnt=5
    bus.en = 1'b1;
    wait_cnt(4);
    pulse_load(SEL_CLK2);
    check_val("t6_busy_cnt5", {bus.sel_busy, m_cnt}, {1'b1, 3'd5});
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_outs", {bus.clk3, bus.clk2, bus.clk1, bus.running, bus.sel_busy}, 5'b0);
    check_val("t6_rst_select", bus.select, SEL_CLK1);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_val("t6_post_select", bus.select, SEL_CLK1);
    check_val("t6_post_busy", bus.sel_busy, 1'b0);

    // en fall and select apply on the same wrap
    wait_cnt(1);
    pulse_load(SEL_CLK3);
    bus.en = 1'b0;
    wait_busy_fall(n);
    check_val("t7_apply_edges", n, 6);
    check_val("t7_select", bus.select, SEL_CLK3);
    check_val("t7_running", bus.running, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
